// File: rtl/eth_frame_gen_64.sv
// Ethernet frame generator: emits one header beat followed by a 64-bit AXI-Stream payload of incrementing bytes.
// Optional macro ETH_FRAME_GEN_SEQ_EN places the frame sequence number (big-endian) in payload bytes 0-3.
module eth_frame_gen_64 #(
   parameter logic [47:0] DEST_MAC = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_00,
   parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] frame_len,
   output logic        busy,
   output logic [31:0] frame_count,
   output logic        output_eth_hdr_valid,
   input  logic        output_eth_hdr_ready,
   output logic [47:0] output_eth_dest_mac,
   output logic [47:0] output_eth_src_mac,
   output logic [15:0] output_eth_type,
   output logic [63:0] output_eth_payload_tdata,
   output logic [7:0]  output_eth_payload_tkeep,
   output logic        output_eth_payload_tvalid,
   input  logic        output_eth_payload_tready,
   output logic        output_eth_payload_tlast,
   output logic        output_eth_payload_tuser
);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

   state_t      state, state_next;
   logic [15:0] len_q;
   logic [12:0] word_idx;
   logic [12:0] last_word;
   logic [31:0] count_q;
   logic        latch;
   logic        is_last;
   logic        word_accept;
   logic [7:0]  last_keep;
   logic [7:0]  word_keep;
   logic [63:0] word_data;
   logic [7:0]  lane_byte;
`ifdef ETH_FRAME_GEN_SEQ_EN
   logic [31:0] seq_q;
`endif

   assign latch       = (state == IDLE) && start && (frame_len != 16'd0);
   assign last_word   = 13'((len_q - 16'd1) >> 3);
   assign is_last     = (word_idx == last_word);
   assign word_accept = (state == PAYLOAD) && output_eth_payload_tready;
   assign last_keep   = (len_q[2:0] == 3'd0) ? 8'hFF : 8'((16'd1 << len_q[2:0]) - 16'd1);
   assign word_keep   = is_last ? last_keep : 8'hFF;

   assign busy                     = (state != IDLE);
   assign frame_count              = count_q;
   assign output_eth_dest_mac      = DEST_MAC;
   assign output_eth_src_mac       = SRC_MAC;
   assign output_eth_type          = ETH_TYPE;
   assign output_eth_payload_tuser = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         word_idx <= '0;
         count_q  <= '0;
`ifdef ETH_FRAME_GEN_SEQ_EN
         seq_q    <= '0;
`endif
      end else begin
         state <= state_next;
         if (latch) begin
            len_q    <= frame_len;
            word_idx <= '0;
`ifdef ETH_FRAME_GEN_SEQ_EN
            seq_q    <= count_q;
`endif
         end
         if (word_accept) begin
            word_idx <= word_idx + 13'd1;
            if (is_last)
               count_q <= count_q + 32'd1;
         end
      end
   end

   // Byte i of the frame carries i[7:0], i.e. {word[4:0], lane}; lanes beyond the length are zeroed
   always_comb begin
      word_data = '0;
      lane_byte = '0;
      for (int k = 0; k < 8; k++) begin
         lane_byte = {word_idx[4:0], 3'(k)};
`ifdef ETH_FRAME_GEN_SEQ_EN
         if (word_idx == 13'd0 && k < 4)
            lane_byte = seq_q[31 - 8*k -: 8];
`endif
         word_data[8*k +: 8] = word_keep[k] ? lane_byte : 8'h00;
      end
   end

   always_comb begin
      state_next                = state;
      output_eth_hdr_valid      = 1'b0;
      output_eth_payload_tvalid = 1'b0;
      output_eth_payload_tlast  = 1'b0;
      output_eth_payload_tkeep  = '0;
      output_eth_payload_tdata  = '0;
      case (state)
         IDLE: begin
            if (latch)
               state_next = HDR;
         end
         HDR: begin
            output_eth_hdr_valid = 1'b1;
            if (output_eth_hdr_ready)
               state_next = PAYLOAD;
         end
         PAYLOAD: begin
            output_eth_payload_tvalid = 1'b1;
            output_eth_payload_tlast  = is_last;
            output_eth_payload_tkeep  = word_keep;
            output_eth_payload_tdata  = word_data;
            if (output_eth_payload_tready && is_last)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_eth_frame_gen_64.sv
// Randomized self-checking bench for eth_frame_gen_64 against a byte-level frame model.
module tb_eth_frame_gen_64;

   localparam logic [47:0] EXP_DEST = 48'hFFFFFFFFFFFF;
   localparam logic [47:0] EXP_SRC  = 48'h02_00_00_00_00_00;
   localparam logic [15:0] EXP_TYPE = 16'h88B5;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] frame_len;
   logic        busy;
   logic [31:0] frame_count;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [47:0] dest_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] exp_count  = 0;

   eth_frame_gen_64 dut (
      .clk                       (clk),
      .rst                       (rst),
      .start                     (start),
      .frame_len                 (frame_len),
      .busy                      (busy),
      .frame_count               (frame_count),
      .output_eth_hdr_valid      (hdr_valid),
      .output_eth_hdr_ready      (hdr_ready),
      .output_eth_dest_mac       (dest_mac),
      .output_eth_src_mac        (src_mac),
      .output_eth_type           (eth_type),
      .output_eth_payload_tdata  (tdata),
      .output_eth_payload_tkeep  (tkeep),
      .output_eth_payload_tvalid (tvalid),
      .output_eth_payload_tready (tready),
      .output_eth_payload_tlast  (tlast),
      .output_eth_payload_tuser  (tuser)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected payload byte at frame offset i, given the sequence number captured at start
   function automatic logic [7:0] expByte(input int i, input logic [31:0] seq);
      logic [7:0] b;
      b = 8'(i);
`ifdef ETH_FRAME_GEN_SEQ_EN
      if (i < 4)
         b = 8'(seq >> (24 - 8*i));
`else
      if (seq == 32'hFFFFFFFF && i < 0)
         b = 8'h00;
`endif
      return b;
   endfunction

   function automatic logic [63:0] expWord(input int len, input int w, input logic [31:0] seq);
      logic [63:0] d;
      d = '0;
      for (int k = 0; k < 8; k++)
         if (8*w + k < len)
            d[8*k +: 8] = expByte(8*w + k, seq);
      return d;
   endfunction

   function automatic logic [7:0] expKeep(input int len, input int w);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 8; k++)
         if (8*w + k < len)
            m[k] = 1'b1;
      return m;
   endfunction

   // Runs one frame request starting at a negedge; random starts/lengths during the frame must be ignored
   task automatic applyStimulus(input int len, input bit stall, input int hdr_hold);
      int          nwords;
      int          guard;
      bit          acc;
      logic [31:0] seq;
      start     = 1'b1;
      frame_len = 16'(len);
      seq       = exp_count;
      @(negedge clk);
      if (len == 0) begin
         start = 1'b0;
         checkOutput("zero_hdr_valid", 64'(hdr_valid), 64'd0);
         checkOutput("zero_busy", 64'(busy), 64'd0);
         checkOutput("zero_count", 64'(frame_count), 64'(exp_count));
         return;
      end
      nwords = (len + 7) / 8;
      guard  = 0;
      acc    = 1'b0;
      while (!acc && guard < 64) begin
         checkOutput("hdr_valid", 64'(hdr_valid), 64'd1);
         checkOutput("hdr_busy", 64'(busy), 64'd1);
         checkOutput("hdr_tvalid", 64'(tvalid), 64'd0);
         checkOutput("hdr_dest", 64'(dest_mac), 64'(EXP_DEST));
         checkOutput("hdr_src", 64'(src_mac), 64'(EXP_SRC));
         checkOutput("hdr_type", 64'(eth_type), 64'(EXP_TYPE));
         start     = 1'($urandom_range(0, 1));
         frame_len = 16'($urandom);
         hdr_ready = (guard < hdr_hold) ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
         acc       = hdr_ready;
         guard++;
         @(negedge clk);
      end
      hdr_ready = 1'b0;
      if (!acc) begin
         checkOutput("hdr_timeout", 64'd0, 64'd1);
         start = 1'b0;
         return;
      end
      for (int w = 0; w < nwords; w++) begin
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 64) begin
            checkOutput("pl_tvalid", 64'(tvalid), 64'd1);
            checkOutput("pl_hdr_valid", 64'(hdr_valid), 64'd0);
            checkOutput("pl_tdata", tdata, expWord(len, w, seq));
            checkOutput("pl_tkeep", 64'(tkeep), 64'(expKeep(len, w)));
            checkOutput("pl_tlast", 64'(tlast), 64'(w == nwords - 1));
            checkOutput("pl_tuser", 64'(tuser), 64'd0);
            start     = 1'($urandom_range(0, 1));
            frame_len = 16'($urandom);
            tready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            acc       = tready;
            guard++;
            @(negedge clk);
         end
         if (!acc) begin
            checkOutput("pl_timeout", 64'd0, 64'd1);
            tready = 1'b0;
            start  = 1'b0;
            return;
         end
      end
      tready = 1'b0;
      start  = 1'b0;
      exp_count++;
      checkOutput("done_busy", 64'(busy), 64'd0);
      checkOutput("done_tvalid", 64'(tvalid), 64'd0);
      checkOutput("done_count", 64'(frame_count), 64'(exp_count));
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      frame_len = '0;
      hdr_ready = 1'b0;
      tready    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
      checkOutput("rst_count", 64'(frame_count), 64'd0);
      checkOutput("rst_dest", 64'(dest_mac), 64'(EXP_DEST));
      checkOutput("rst_type", 64'(eth_type), 64'(EXP_TYPE));
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(20, 1'b0, 0);
      applyStimulus(16, 1'b1, 0);
      applyStimulus(40, 1'b0, 10);
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);

      // Reset while word index 2 of a 64-byte frame is on the bus
      start     = 1'b1;
      frame_len = 16'd64;
      @(negedge clk);
      start     = 1'b0;
      hdr_ready = 1'b1;
      @(negedge clk);
      hdr_ready = 1'b0;
      tready    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("pre_rst_tdata", tdata, expWord(64, 2, exp_count));
      rst = 1'b1;
      #1;
      checkOutput("midrst_tvalid", 64'(tvalid), 64'd0);
      checkOutput("midrst_tlast", 64'(tlast), 64'd0);
      checkOutput("midrst_tdata", tdata, 64'd0);
      checkOutput("midrst_tkeep", 64'(tkeep), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_count", 64'(frame_count), 64'd0);
      checkOutput("midrst_src", 64'(src_mac), 64'(EXP_SRC));
      tready = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      exp_count = 0;
      @(negedge clk);

      applyStimulus(8, 1'b0, 0);
      applyStimulus(8, 1'b1, 0);
      applyStimulus(8, 1'b0, 0);

      for (int n = 0; n < 25; n++)
         applyStimulus(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

      applyStimulus(65535, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
